// File: rtl/tree_pkg.sv
// ============================================================================
// Package : tree_pkg
// Brief   : Shared tree-node field layout, leaf codes, walker FSM states and
//           the IEEE-754 double order-key helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tree_pkg;

  localparam int ID_LSB    = 96;
  localparam int ID_W      = 12;
  localparam int FEAT_LSB  = 92;
  localparam int FEAT_W    = 4;
  localparam int THR_LSB   = 28;
  localparam int THR_W     = 64;
  localparam int LEFT_LSB  = 16;
  localparam int RIGHT_LSB = 4;
  localparam int CHILD_W   = 12;
  localparam int TAG_LSB   = 0;
  localparam int TAG_W     = 4;

  localparam logic [TAG_W-1:0]  LEAF_TAG       = 4'h3;
  localparam logic [FEAT_W-1:0] FEAT_LEAF_CODE = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } walk_state_t;

  // Maps a double onto an unsigned key whose ordering matches numeric order
  // (with -0.0 just below +0.0).
  function automatic logic [63:0] order_key(input logic [63:0] x);
    order_key = x[63] ? ~x : {~x[63], x[62:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp64_le.sv
// ============================================================================
// Module : fp64_le
// Brief  : Combinational a <= b for 64-bit doubles via order keys (no NaN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp64_le
  import tree_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le
);

  assign le = (order_key(a) <= order_key(b));

endmodule

`default_nettype wire

// File: rtl/tree_walker.sv
// ============================================================================
// Module : tree_walker
// Brief  : Walks one decision tree in a 1-cycle-latency ROM per request and
//          returns the leaf class. Optional depth guard: TREE_WALKER_DEPTH_GUARD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tree_walker
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int ROOT_ADDR    = 0,
  parameter int MAX_DEPTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [64*NUM_FEATURES-1:0] in_features,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [NODE_WIDTH-1:0]      rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_class,
  output logic [5:0]                 out_depth,
  output logic                       out_err
);

  localparam logic [ADDR_WIDTH-1:0] ROOT_PTR    = ADDR_WIDTH'(ROOT_ADDR);
  localparam logic [CHILD_W-1:0]    ROOT_CHILD  = CHILD_W'(ROOT_ADDR);
  localparam logic [CHILD_W:0]      ROM_DEPTH_L = (CHILD_W+1)'(ROM_DEPTH);
  localparam logic [FEAT_W:0]       NUM_FEAT_L  = (FEAT_W+1)'(NUM_FEATURES);

  walk_state_t                r_state;
  walk_state_t                w_state_nxt;
  logic [64*NUM_FEATURES-1:0] r_features;
  logic [ADDR_WIDTH-1:0]      r_ptr;
  logic                       r_in_ready;
  logic [3:0]                 r_class;
  logic [5:0]                 r_depth;
  logic                       r_err;

  logic [FEAT_W-1:0]  w_fidx;
  logic [THR_W-1:0]   w_thr;
  logic [CHILD_W-1:0] w_left;
  logic [CHILD_W-1:0] w_right;
  logic [CHILD_W-1:0] w_child;
  logic [TAG_W-1:0]   w_tag;
  logic [63:0]        w_feature;
  logic               w_is_leaf;
  logic               w_go_left;
  logic               w_id_bad;
  logic               w_feat_bad;
  logic               w_child_bad;
  logic               w_guard_hit;
  logic               w_eval_err;
  logic               w_accept;

  assign w_fidx    = rom_data[FEAT_LSB  +: FEAT_W];
  assign w_thr     = rom_data[THR_LSB   +: THR_W];
  assign w_left    = rom_data[LEFT_LSB  +: CHILD_W];
  assign w_right   = rom_data[RIGHT_LSB +: CHILD_W];
  assign w_tag     = rom_data[TAG_LSB   +: TAG_W];
  assign w_is_leaf = (w_tag != LEAF_TAG);

  // Reserved bits above the id are zero in a good word, so any set bit there
  // is treated as an id mismatch.
  assign w_id_bad = (rom_data[ID_LSB +: ID_W] != ID_W'(r_ptr)) ||
                    (|rom_data[NODE_WIDTH-1:ID_LSB+ID_W]);

  always_comb begin
    w_feature = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (w_fidx == FEAT_W'(i)) w_feature = r_features[64*i +: 64];
    end
  end

  fp64_le u_le (
    .a  (w_feature),
    .b  (w_thr),
    .le (w_go_left)
  );

  assign w_child     = w_go_left ? w_left : w_right;
  assign w_feat_bad  = ({1'b0, w_fidx} >= NUM_FEAT_L);
  assign w_child_bad = ({1'b0, w_child} >= ROM_DEPTH_L) || (w_child == ROOT_CHILD);

`ifdef TREE_WALKER_DEPTH_GUARD_EN
  localparam logic [5:0] MAX_DEPTH_L = 6'(MAX_DEPTH);
  assign w_guard_hit = (r_depth >= MAX_DEPTH_L);
`else
  assign w_guard_hit = 1'b0;
`endif

  assign w_eval_err = w_id_bad || (!w_is_leaf && (w_feat_bad || w_child_bad || w_guard_hit));
  assign w_accept   = (r_state == ST_IDLE) && r_in_ready && in_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_EVAL;
      ST_EVAL:  w_state_nxt = (w_eval_err || w_is_leaf) ? ST_DONE : ST_FETCH;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_features <= '0;
      r_ptr      <= ROOT_PTR;
      r_class    <= '0;
      r_depth    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_features <= in_features;
            r_ptr      <= ROOT_PTR;
            r_depth    <= '0;
            r_class    <= '0;
            r_err      <= 1'b0;
          end
        end
        ST_EVAL: begin
          if (w_eval_err) begin
            r_err   <= 1'b1;
            r_class <= '0;
          end else if (w_is_leaf) begin
            r_class <= w_tag;
          end else begin
            r_ptr   <= w_child[ADDR_WIDTH-1:0];
            r_depth <= r_depth + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign rom_addr  = r_ptr;
  assign out_valid = (r_state == ST_DONE);
  assign out_class = r_class;
  assign out_depth = r_depth;
  assign out_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tree_walker.sv
// ============================================================================
// Module : tb_tree_walker
// Brief  : Scoreboard bench for tree_walker with a behavioural tree-walk model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tree_walker;

`ifdef TREE_WALKER_DEPTH_GUARD_EN
  localparam int MAXD = 2;
`else
  localparam int MAXD = 32;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] in_features;
  logic [9:0]    rom_addr;
  logic [119:0]  rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_class;
  logic [5:0]    out_depth;
  logic          out_err;

  tree_walker #(.MAX_DEPTH(MAXD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_features (in_features),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .out_depth   (out_depth),
    .out_err     (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [119:0] mem [0:1023];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] cls;
    int         depth;
    bit         err;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit fle(input logic [63:0] a, input logic [63:0] b);
    if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return !(a[63] == 1'b0 && b[63] == 1'b1);
    return $bitstoreal(a) <= $bitstoreal(b);
  endfunction

  function automatic exp_t model(input logic [1023:0] f);
    exp_t         e;
    logic [119:0] w;
    int           ptr;
    int           fi;
    int           child;
    e.cls = 4'd0; e.depth = 0; e.err = 1'b0; e.due = 0;
    ptr = 0;
    for (int step = 0; step < 100; step++) begin
      w = mem[ptr];
      if (w[119:96] != 24'(ptr)) begin e.err = 1'b1; return e; end
      if (w[3:0] != 4'h3) begin e.cls = w[3:0]; return e; end
      fi = int'(w[95:92]);
      if (fi >= 16) begin e.err = 1'b1; return e; end
`ifdef TREE_WALKER_DEPTH_GUARD_EN
      if (e.depth >= MAXD) begin e.err = 1'b1; return e; end
`endif
      child = fle(f[64*fi +: 64], w[91:28]) ? int'(w[27:16]) : int'(w[15:4]);
      if (child >= 512 || child == 0) begin e.err = 1'b1; return e; end
      ptr = child;
      e.depth++;
    end
    return e;
  endfunction

  function automatic logic [119:0] inode(input int id, input int fi, input logic [63:0] thr,
                                         input int l, input int r);
    logic [119:0] w;
    w = '0;
    w[107:96] = 12'(id); w[95:92] = 4'(fi); w[91:28] = thr;
    w[27:16] = 12'(l); w[15:4] = 12'(r); w[3:0] = 4'h3;
    return w;
  endfunction

  function automatic logic [119:0] leaf(input int id, input int cls);
    logic [119:0] w;
    w = '0;
    w[107:96] = 12'(id); w[95:92] = 4'h3; w[3:0] = 4'(cls);
    return w;
  endfunction

  logic [63:0] pool [8] = '{64'h0000000000000000, 64'h8000000000000000, 64'h3FF0000000000000,
                            64'hBFF0000000000000, 64'h4004000000000000, 64'hC004000000000000,
                            64'h4202A05F20000000, 64'hC008000000000000};

  function automatic logic [63:0] pick_val();
    logic [63:0] v;
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
    v = {$urandom(), $urandom()};
    v[62:52] = 11'h3F8 + 11'($urandom_range(0, 15));
    return v;
  endfunction

  function automatic logic [1023:0] rand_feats();
    logic [1023:0] f;
    for (int i = 0; i < 16; i++) f[64*i +: 64] = pick_val();
    return f;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic plan_tree();
    clear_mem();
    mem[0] = inode(0, 0, 64'h41D8EC3390000000, 1, 2);
    mem[1] = inode(1, 1, 64'h4068100000000000, 3, 4);
    mem[2] = leaf(2, 0);
    mem[3] = leaf(3, 1);
    mem[4] = leaf(4, 0);
  endtask

  // ---------------- monitor ----------------
  bit          seen = 0;
  bit          prev_hs = 0;
  logic [10:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 0;
      prev_hs = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        held = {out_class, out_depth, out_err};
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("class", 64'(out_class), 64'(e.cls));
          chk("depth", 64'(out_depth), 64'(6'(e.depth)));
          chk("err", 64'(out_err), 64'(e.err));
          chk("latency_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("hold_stable", 64'({out_class, out_depth, out_err}), 64'(held));
      end
      chk("in_ready_while_done", 64'(in_ready), 64'd0);
      if (out_ready) prev_hs = 1;
    end else begin
      if (prev_hs) chk("in_ready_after_accept", 64'(in_ready), 64'd1);
      prev_hs = 0;
      seen = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input logic [1023:0] f, input int hold);
    exp_t e;
    wait_ready();
    e = model(f);
    in_features = f;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    e.due = cyc + 2 * (e.depth + 1);
    q.push_back(e);
    in_valid    = 1'b0;
    in_features = rand_feats();
    wait_valid();
    if (hold > 0) in_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      in_features = rand_feats();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [1023:0] f01(input logic [63:0] a, input logic [63:0] b);
    logic [1023:0] f;
    f = '0;
    f[63:0]   = a;
    f[127:64] = b;
    return f;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_features = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_outputs", 64'({out_valid, out_class, out_depth, out_err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    plan_tree();
    run(f01(64'h41D0000000000000, 64'h4060000000000000), 0);
    run(f01(64'h41E0000000000000, 64'h4060000000000000), 1);

    clear_mem();
    mem[0] = inode(0, 0, 64'h0000000000000000, 1, 2);
    mem[1] = leaf(1, 5);
    mem[2] = leaf(2, 9);
    run(f01(64'hBFF0000000000000, 64'h0), 0);
    run(f01(64'h0000000000000000, 64'h0), 0);
    run(f01(64'h3FF0000000000000, 64'h0), 2);
    run(f01(64'h8000000000000000, 64'h0), 0);
    mem[0] = inode(0, 0, 64'h8000000000000000, 1, 2);
    run(f01(64'h0000000000000000, 64'h0), 0);

    plan_tree();
    run(f01(64'h41D0000000000000, 64'h4060000000000000), 5);

    mem[1] = inode(5, 1, 64'h4068100000000000, 3, 4);
    run(f01(64'h41D0000000000000, 64'h4060000000000000), 0);

    plan_tree();
    mem[0] = inode(0, 0, 64'h41D8EC3390000000, 12'h200, 2);
    run(f01(64'h41D0000000000000, 64'h4060000000000000), 0);
    plan_tree();
    mem[1] = inode(1, 1, 64'h4068100000000000, 0, 4);
    run(f01(64'h41D0000000000000, 64'h4060000000000000), 0);

    clear_mem();
    mem[0] = inode(0, 0, 64'h41D8EC3390000000, 1, 9);
    mem[1] = inode(1, 0, 64'h41D8EC3390000000, 2, 9);
    mem[2] = inode(2, 0, 64'h41D8EC3390000000, 3, 9);
    mem[3] = leaf(3, 7);
    mem[9] = leaf(9, 2);
    run(f01(64'h0, 64'h0), 0);

    plan_tree();
    wait_ready();
    in_features = f01(64'h41D0000000000000, 64'h4060000000000000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fetch_addr", 64'(rom_addr), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midwalk_rst_in_ready", 64'(in_ready), 64'd0);
    chk("midwalk_rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("midwalk_rst_outputs", 64'({out_valid, out_class, out_depth, out_err}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_output_after_rst", 64'(out_valid), 64'd0);
    chk("idle_after_rst", 64'(in_ready), 64'd1);

    clear_mem();
    for (int i = 0; i < 63; i++) begin
      int cls;
      cls = $urandom_range(0, 14);
      if (cls >= 3) cls++;
      if (i < 31 && (i < 3 || $urandom_range(0, 3) != 0))
        mem[i] = inode(i, $urandom_range(0, 15), pick_val(), 2 * i + 1, 2 * i + 2);
      else
        mem[i] = leaf(i, cls);
    end
    for (int k = 0; k < 40; k++) run(rand_feats(), $urandom_range(0, 3));

    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
